// File: rtl/pacman_pkg.sv
// Shared types and constants for the pacman map writer: cell codes, FSM states,
// coordinate widths and the map address mapping.
package pacman_pkg;

    localparam int MAP_W  = 40;
    localparam int MAP_H  = 30;
    localparam int X_W    = 6;
    localparam int Y_W    = 5;
    localparam int ADDR_W = X_W + Y_W;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        WALL   = 2'd1,
        DOT    = 2'd2,
        PACMAN = 2'd3
    } cell_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOUND,
        S_READ,
        S_CHECK,
        S_ERASE,
        S_DRAW,
        S_DONE,
        S_BLOCK
    } state_t;

    // Row-major map address: the row occupies the upper bits.
    function automatic logic [ADDR_W-1:0] map_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/pacman_map_writer_if.sv
// Map RAM port: the writer drives address/write data/enable and receives read
// data one cycle after the address.
interface pacman_map_writer_if;
    import pacman_pkg::*;

    logic [ADDR_W-1:0] ram_addr;
    cell_t             ram_wdata;
    logic              ram_we;
    cell_t             ram_rdata;

    modport master (output ram_addr, output ram_wdata, output ram_we, input ram_rdata);
    modport slave  (input ram_addr, input ram_wdata, input ram_we, output ram_rdata);

endinterface

// File: rtl/sat_counter.sv
// Up counter that holds at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pacman_map_writer.sv
// Commits pacman moves into the map RAM: bounds check, wall check via a RAM read,
// then erase the old cell, draw the new one, and report done or blocked.
module pacman_map_writer #(
    parameter int MAP_W = pacman_pkg::MAP_W,
    parameter int MAP_H = pacman_pkg::MAP_H,
    parameter int CNT_W = 10
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [5:0]            curr_pacman_x,
    input  logic [4:0]            curr_pacman_y,
    input  logic [5:0]            next_pacman_x,
    input  logic [4:0]            next_pacman_y,
    pacman_map_writer_if.master   ram,
    output logic                  done,
    output logic                  blocked,
    output logic                  dot_eaten,
    output logic [CNT_W-1:0]      dot_count,
    output pacman_pkg::state_t    fsm_state
);
    import pacman_pkg::*;

    localparam logic [X_W-1:0] X_LIM = X_W'(MAP_W);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(MAP_H);

    state_t          state;
    state_t          state_nx;
    logic [X_W-1:0]  snap_cx;
    logic [Y_W-1:0]  snap_cy;
    logic [X_W-1:0]  snap_nx;
    logic [Y_W-1:0]  snap_ny;
    logic            is_dot;
    logic            req;

    assign req = {next_pacman_x, next_pacman_y} != {curr_pacman_x, curr_pacman_y};

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Coordinates are frozen at acceptance; input changes mid-move are ignored.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            snap_cx <= '0;
            snap_cy <= '0;
            snap_nx <= '0;
            snap_ny <= '0;
            is_dot  <= 1'b0;
        end else begin
            if ((state == S_IDLE) && req) begin
                snap_cx <= curr_pacman_x;
                snap_cy <= curr_pacman_y;
                snap_nx <= next_pacman_x;
                snap_ny <= next_pacman_y;
            end
            if (state == S_CHECK) begin
                is_dot <= (ram.ram_rdata == DOT);
            end
        end
    end

    always_comb begin
        state_nx      = state;
        ram.ram_addr  = '0;
        ram.ram_wdata = EMPTY;
        ram.ram_we    = 1'b0;
        done          = 1'b0;
        blocked       = 1'b0;
        dot_eaten     = 1'b0;
        case (state)
            S_IDLE:  if (req) state_nx = S_BOUND;
            // Underflow past column/row 0 wraps to 63/31 and lands here as well.
            S_BOUND: state_nx = ((snap_nx >= X_LIM) || (snap_ny >= Y_LIM)) ? S_BLOCK : S_READ;
            S_READ: begin
                ram.ram_addr = map_addr(snap_nx, snap_ny);
                state_nx     = S_CHECK;
            end
            S_CHECK: state_nx = (ram.ram_rdata == WALL) ? S_BLOCK : S_ERASE;
            S_ERASE: begin
                ram.ram_we    = 1'b1;
                ram.ram_addr  = map_addr(snap_cx, snap_cy);
                ram.ram_wdata = EMPTY;
                state_nx      = S_DRAW;
            end
            S_DRAW: begin
                ram.ram_we    = 1'b1;
                ram.ram_addr  = map_addr(snap_nx, snap_ny);
                ram.ram_wdata = PACMAN;
                state_nx      = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                dot_eaten = is_dot;
                state_nx  = S_IDLE;
            end
            S_BLOCK: begin
                blocked  = 1'b1;
                state_nx = S_IDLE;
            end
        endcase
    end

    sat_counter #(.CNT_W(CNT_W)) u_dot_cnt (
        .clk   (CLOCK_50),
        .rst   (reset),
        .inc   ((state == S_DONE) && is_dot),
        .clear (1'b0),
        .count (dot_count)
    );

    assign fsm_state = state;

endmodule

// File: tb/tb_pacman_map_writer.sv
// Bench for pacman_map_writer: RAM model, per-move expected timeline derived from
// the move rules, a per-cycle compare process, and directed plus random moves.
module tb_pacman_map_writer;
    import pacman_pkg::*;

    typedef struct packed {
        logic        we;
        logic [10:0] addr;
        logic [1:0]  wdata;
        logic [1:0]  amode;   // 0: don't care, 1: must equal addr, 2: must differ
        logic        done;
        logic        blocked;
        logic        eaten;
        logic [9:0]  cnt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [5:0]  curr_x;
    logic [4:0]  curr_y;
    logic [5:0]  next_x;
    logic [4:0]  next_y;
    logic        done;
    logic        blocked;
    logic        dot_eaten;
    logic [9:0]  dot_count;
    state_t      fsm_state;

    pacman_map_writer_if ram_bus();

    pacman_map_writer dut (
        .CLOCK_50      (clk),
        .reset         (reset),
        .curr_pacman_x (curr_x),
        .curr_pacman_y (curr_y),
        .next_pacman_x (next_x),
        .next_pacman_y (next_y),
        .ram           (ram_bus),
        .done          (done),
        .blocked       (blocked),
        .dot_eaten     (dot_eaten),
        .dot_count     (dot_count),
        .fsm_state     (fsm_state)
    );

    int         checks = 0;
    int         failures = 0;
    int         model_cnt = 0;
    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [1:0] mem [0:2047];
    logic [1:0] ref_map [0:2047];

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Map RAM: synchronous write, registered read
    always @(posedge clk) begin
        if (ram_bus.ram_we) mem[ram_bus.ram_addr] <= ram_bus.ram_wdata;
        ram_bus.ram_rdata <= cell_t'(mem[ram_bus.ram_addr]);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: one expected entry per cycle while a move is in flight
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("done", 32'(done), 32'(mon_e.done));
            chk("blocked", 32'(blocked), 32'(mon_e.blocked));
            chk("dot_eaten", 32'(dot_eaten), 32'(mon_e.eaten));
            chk("ram_we", 32'(ram_bus.ram_we), 32'(mon_e.we));
            chk("dot_count", 32'(dot_count), 32'(mon_e.cnt));
            if (mon_e.we) chk("ram_wdata", 32'(ram_bus.ram_wdata), 32'(mon_e.wdata));
            if (mon_e.amode == 2'd1) chk("ram_addr", 32'(ram_bus.ram_addr), 32'(mon_e.addr));
            if (mon_e.amode == 2'd2) begin
                checks++;
                if (ram_bus.ram_addr == mon_e.addr) begin
                    failures++;
                    $display("FAIL ram_addr_not_target actual=%0d must differ from %0d at %0t",
                             ram_bus.ram_addr, mon_e.addr, $time);
                end
            end
        end
    end

    task automatic set_cell(input logic [10:0] a, input logic [1:0] v);
        ref_map[a] = v;
        mem[a] <= v;
    endtask

    // Driver: called just after a rising edge with the DUT idle; returns likewise.
    task automatic do_move(input logic [5:0] cx, input logic [4:0] cy,
                           input logic [5:0] nx, input logic [4:0] ny, input bit glitch);
        logic [10:0] ta, ca;
        logic        oob, wall, legal, dot;
        int          kend, newc;
        exp_t        e;
        ta    = {ny, nx};
        ca    = {cy, cx};
        oob   = (nx >= 6'd40) || (ny >= 5'd30);
        wall  = !oob && (ref_map[ta] == 2'd1);
        legal = !oob && !wall;
        dot   = legal && (ref_map[ta] == 2'd2);
        newc  = (dot && model_cnt != 1023) ? model_cnt + 1 : model_cnt;
        kend  = oob ? 2 : (wall ? 4 : 6);
        for (int c = 0; c <= kend + 1; c++) begin
            e     = '0;
            e.cnt = 10'((c == kend + 1) ? newc : model_cnt);
            if (oob) begin
                e.amode = 2'd2;
                e.addr  = ta;
            end else if (c == 2) begin
                e.amode = 2'd1;
                e.addr  = ta;
            end
            if (legal && c == 4) begin
                e.we = 1'b1; e.addr = ca; e.wdata = 2'd0; e.amode = 2'd1;
            end
            if (legal && c == 5) begin
                e.we = 1'b1; e.addr = ta; e.wdata = 2'd3; e.amode = 2'd1;
            end
            if (c == kend) begin
                e.done    = legal;
                e.blocked = !legal;
                e.eaten   = dot;
            end
            exp_q.push_back(e);
        end
        curr_x = cx; curr_y = cy; next_x = nx; next_y = ny;
        for (int c = 1; c <= kend + 1; c++) begin
            @(posedge clk); #1;
            if (glitch && c == 3) next_x = nx ^ 6'h15;
            if (c == kend + 1) begin
                if (legal) begin
                    curr_x = nx; curr_y = ny; next_x = nx; next_y = ny;
                end else begin
                    next_x = cx; next_y = cy;
                end
            end
        end
        @(posedge clk); #1;
        if (legal) begin
            ref_map[ca] = 2'd0;
            ref_map[ta] = 2'd3;
            model_cnt   = newc;
        end
    endtask

    initial begin
        int bad;
        reset = 1'b1;
        curr_x = '0; curr_y = '0; next_x = '0; next_y = '0;
        for (int i = 0; i < 2048; i++) begin
            ref_map[i] = 2'd0;
            mem[i] <= 2'd0;
        end
        #1;
        chk("rst_ram_addr", 32'(ram_bus.ram_addr), 0);
        chk("rst_ram_we", 32'(ram_bus.ram_we), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_blocked", 32'(blocked), 0);
        chk("rst_dot_eaten", 32'(dot_eaten), 0);
        chk("rst_dot_count", 32'(dot_count), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Dot target straight up
        set_cell({5'd19, 6'd20}, 2'd2);
        do_move(6'd20, 5'd20, 6'd20, 5'd19, 1'b0);
        chk("t1_dot_count", 32'(dot_count), 1);
        chk("t1_model_cnt", 32'(model_cnt), 1);
        chk("t1_ram_drawn", 32'(mem[1236]), 3);
        chk("t1_ram_erased", 32'(mem[1300]), 0);

        // Wall target
        set_cell({5'd20, 6'd21}, 2'd1);
        do_move(6'd20, 5'd20, 6'd21, 5'd20, 1'b0);
        chk("t2_dot_count", 32'(dot_count), 1);
        chk("t2_wall_kept", 32'(mem[1301]), 1);

        // Left wrap out of bounds
        do_move(6'd0, 5'd5, 6'd63, 5'd5, 1'b0);
        chk("t3_dot_count", 32'(dot_count), 1);

        // Empty target with next_x disturbed during the check
        set_cell({5'd5, 6'd5}, 2'd0);
        do_move(6'd4, 5'd5, 6'd5, 5'd5, 1'b1);
        chk("t4_ram_drawn", 32'(mem[325]), 3);
        chk("t4_dot_count", 32'(dot_count), 1);

        // Random moves
        for (int i = 0; i < 120; i++) begin
            logic [5:0] cx, nx;
            logic [4:0] cy, ny;
            int d;
            cx = 6'($urandom_range(0, 39));
            cy = 5'($urandom_range(0, 29));
            d  = $urandom_range(0, 3);
            nx = cx; ny = cy;
            case (d)
                0: ny = cy - 5'd1;
                1: ny = cy + 5'd1;
                2: nx = cx - 6'd1;
                default: nx = cx + 6'd1;
            endcase
            if ($urandom_range(0, 7) == 0) nx = 6'($urandom_range(40, 63));
            if (nx < 6'd40 && ny < 5'd30) set_cell({ny, nx}, 2'($urandom_range(0, 3)));
            do_move(cx, cy, nx, ny, $urandom_range(0, 3) == 0);
        end

        // Reset while erasing
        set_cell({5'd10, 6'd30}, 2'd0);
        curr_x = 6'd29; curr_y = 5'd10; next_x = 6'd30; next_y = 5'd10;
        repeat (4) @(posedge clk);
        #1;
        chk("t5_erase_we", 32'(ram_bus.ram_we), 1);
        chk("t5_erase_addr", 32'(ram_bus.ram_addr), 32'({5'd10, 6'd29}));
        #1 reset = 1'b1;
        #1;
        chk("t5_we", 32'(ram_bus.ram_we), 0);
        chk("t5_addr", 32'(ram_bus.ram_addr), 0);
        chk("t5_done", 32'(done), 0);
        chk("t5_blocked", 32'(blocked), 0);
        chk("t5_dot_count", 32'(dot_count), 0);
        chk("t5_state", 32'(fsm_state), 32'(S_IDLE));
        next_x = curr_x; next_y = curr_y;
        model_cnt = 0;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        // Saturation: 1024 dot moves
        for (int i = 0; i < 1024; i++) begin
            if (i % 2 == 0) begin
                set_cell({5'd10, 6'd11}, 2'd2);
                do_move(6'd10, 5'd10, 6'd11, 5'd10, 1'b0);
            end else begin
                set_cell({5'd10, 6'd10}, 2'd2);
                do_move(6'd11, 5'd10, 6'd10, 5'd10, 1'b0);
            end
        end
        chk("t6_dot_count", 32'(dot_count), 1023);
        chk("t6_model_cnt", 32'(model_cnt), 1023);

        bad = 0;
        for (int y = 0; y < 30; y++)
            for (int x = 0; x < 40; x++)
                if (mem[y * 64 + x] !== ref_map[y * 64 + x]) bad++;
        chk("map_contents", 32'(bad), 0);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
